systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Parametrised sequencer for an N x N output-stationary systolic array. It replaces the fixed 4x4 start/stop schedule plus the external delay-line skew.
- One start/done job computes C = A(N x K) * B(K x N). K is supplied per job.
- Generates per-lane skewed read addresses and per-lane valid flags for the A and B banks.
- Generates per-anti-diagonal PE enables, the PE accumulator clear, and the one-cycle output-memory write strobe.
- Sits between the instruction/host front end and the PE array, the A/B banks and the C bank.

Parameters:
- N, 4, array dimension: lanes per bank; 2N-1 PE enable diagonals.
- AW, 7, data-memory address width.
- KW, 7, width of K (inner dimension).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- k_len  in  KW  inner dimension K for the job.
- base_a  in  AW  base address of A; A is row-major, K words per row.
- base_b  in  AW  base address of B; B is column-major, K words per column.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse when start is rejected.
- rd_addr_a  out  N*AW  lane r address in bits [r*AW +: AW].
- rd_vld_a  out  N  lane valid; the consumer zeroes the operand when low.
- rd_addr_b  out  N*AW  lane c address, same packing as rd_addr_a.
- rd_vld_b  out  N  lane valid for B.
- pe_en  out  2N-1  bit d enables every PE(i,j) with i+j = d.
- pe_clr  out  1  clears all PE accumulators.
- c_wr_en  out  1  latches all N*N PE results into the C bank.

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0 at a clk edge) forces state IDLE and all counters to 0. This applies mid-job too.
- Reset values: busy, done and err are 0; rd_vld_a, rd_vld_b, pe_en, pe_clr and c_wr_en are 0; rd_addr_a and rd_addr_b are 0.
- States are IDLE, CLEAR, RUN and WRITE. A 1-cycle done pulse is issued on the WRITE -> IDLE transition.
- IDLE with start = 1 and k_len != 0:
  - latch K, base_a and base_b;
  - go to CLEAR; busy goes to 1.
- IDLE with start = 1 and k_len = 0: no job; err pulses for 1 cycle; stay in IDLE.
- start while busy is ignored; no queueing.
- CLEAR (1 cycle): pe_clr = 1; run counter c is loaded with 0.
- RUN, with c counting 0 to K+2N-2:
  - rd_vld_a[r] = 1 iff r <= c <= r+K-1.
  - rd_addr_a[r] = base_a + r*K + (c - r).
  - rd_vld_b and rd_addr_b follow identical rules using base_b.
  - When a lane is invalid its address holds 0.
  - pe_en[d] = 1 iff d+1 <= c <= d+K. This accounts for the 1-cycle memory read latency.
- After c = K+2N-2: go to WRITE. WRITE lasts 1 cycle with c_wr_en = 1.
- Then go to IDLE with done = 1 for 1 cycle and busy = 0.
- A new start is accepted in the same cycle done is high.
- Latency: done is high exactly K+2N+1 cycles after the edge that accepted start.
- Address arithmetic:
  - r*K is formed at AW bits;
  - all sums wrap modulo 2^AW;
  - there is no overflow flag. Software guarantees base + N*K <= 2^AW.
- K = 1 is legal. Each lane is valid for exactly one cycle, and each pe_en bit is high for one cycle.
- abort = 1 in any non-IDLE state:
  - next state is IDLE;
  - all strobes and enables are cleared;
  - no done pulse, and c_wr_en is never issued.
- abort in IDLE has no effect.
- abort and reset both win over start in the same cycle.

Decomposition:
- Shared package systolic_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, WRITE);
  - default N, AW and KW;
  - a function for the lane address offset.
- Sub-module seq_lane_gen: one skewed lane.
  - Inputs: c, lane index, K, base.
  - Outputs: addr, vld.
  - Instantiated N times per bank via generate.
- The top level keeps the FSM, the run counter and the pe_en decode.

Test Plan:
- N=4, K=4, base_a=0, base_b=64, start pulse:
  - rd_addr_a lane0 = 0,1,2,3 at c = 0..3;
  - lane3 = 12,13,14,15 at c = 3..6;
  - rd_addr_b lane1 = 68..71 at c = 1..4;
  - pe_en[0] high c = 1..4, pe_en[6] high c = 7..10;
  - c_wr_en once; done exactly 13 cycles after accept.
- N=4, K=1:
  - every lane valid one cycle, at c = r;
  - pe_en[d] high only at c = d+1;
  - done 10 cycles after accept.
- start with k_len=0: err pulses 1 cycle; busy, pe_clr and done stay 0.
- start re-asserted mid-job (c=5) is ignored. A second start in the done cycle is accepted: pe_clr is high the next cycle.
- abort at c=3: next cycle all outputs 0 and state IDLE; c_wr_en and done never assert.
- rst_n=0 at c=6: next cycle every output is at its reset value. With rst_n released and start held, the next job runs normally.
- Wrap check, N=4, K=8, base_a=100: lane3 c=10 addresses (100+24+7) mod 128 = 3.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 7;
    localparam int KW_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_WRITE
    } state_e;

    // Start of a lane's row/column inside its bank; callers truncate to AW bits.
    function automatic logic [31:0] lane_offset(input logic [31:0] lane, input logic [31:0] k);
        return lane * k;
    endfunction

endpackage

// File: rtl/seq_lane_gen.sv
// One skewed operand lane: lane r reads element (c - r) of its K-word row/column.
module seq_lane_gen
    import systolic_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int KW = KW_DEF,
    parameter int CW = KW_DEF + 2
) (
    input  logic [CW-1:0] c,
    input  logic [CW-1:0] lane,
    input  logic [KW-1:0] k_len,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] addr,
    output logic          vld
);

    logic [AW-1:0] offset;
    logic [AW-1:0] step;

    assign offset = AW'(lane_offset(32'(lane), 32'(k_len)));
    assign step   = AW'(c - lane);
    assign vld    = (c >= lane) && (c < lane + CW'(k_len));
    assign addr   = vld ? (base + offset + step) : '0;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: FSM, run counter,
// skewed A/B read lanes and anti-diagonal PE enables, all outputs registered.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [KW-1:0]   k_len,
    input  logic [AW-1:0]   base_a,
    input  logic [AW-1:0]   base_b,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [N*AW-1:0] rd_addr_a,
    output logic [N-1:0]    rd_vld_a,
    output logic [N*AW-1:0] rd_addr_b,
    output logic [N-1:0]    rd_vld_b,
    output logic [2*N-2:0]  pe_en,
    output logic            pe_clr,
    output logic            c_wr_en
);

    localparam int CW = KW + 2;
    localparam int ND = 2 * N - 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [KW-1:0]     k_q, k_d;
    logic [AW-1:0]     base_a_q, base_a_d, base_b_q, base_b_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              pe_clr_q, pe_clr_d, c_wr_en_q, c_wr_en_d;
    logic [N*AW-1:0]   rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic [N-1:0]      rd_vld_a_q, rd_vld_a_d, rd_vld_b_q, rd_vld_b_d;
    logic [ND-1:0]     pe_en_q, pe_en_d;

    logic [AW-1:0]     lane_addr_a [N];
    logic [AW-1:0]     lane_addr_b [N];
    logic [N-1:0]      lane_vld_a, lane_vld_b;
    logic [CW-1:0]     last_c;
    logic              run_d;

    // Lanes see next-cycle counter values so their results land in the output flops.
    for (genvar r = 0; r < N; r++) begin : g_lane
        seq_lane_gen #(.AW(AW), .KW(KW), .CW(CW)) u_lane_a (
            .c     (c_d),
            .lane  (CW'(r)),
            .k_len (k_d),
            .base  (base_a_d),
            .addr  (lane_addr_a[r]),
            .vld   (lane_vld_a[r])
        );
        seq_lane_gen #(.AW(AW), .KW(KW), .CW(CW)) u_lane_b (
            .c     (c_d),
            .lane  (CW'(r)),
            .k_len (k_d),
            .base  (base_b_d),
            .addr  (lane_addr_b[r]),
            .vld   (lane_vld_b[r])
        );
    end

    assign last_c = CW'(k_q) + CW'(2 * N - 2);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        c_d      = c_q;
        k_d      = k_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (k_len != '0) begin
                        k_d      = k_len;
                        base_a_d = base_a;
                        base_b_d = base_b;
                        state_d  = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                c_d     = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (c_q == last_c) state_d = ST_WRITE;
                else               c_d     = c_q + CW'(1);
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            c_d     = '0;
            done_d  = 1'b0;
        end

        run_d     = (state_d == ST_RUN);
        busy_d    = (state_d != ST_IDLE);
        pe_clr_d  = (state_d == ST_CLEAR);
        c_wr_en_d = (state_d == ST_WRITE);

        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        rd_vld_a_d  = '0;
        rd_vld_b_d  = '0;
        for (int r = 0; r < N; r++) begin
            rd_vld_a_d[r] = run_d && lane_vld_a[r];
            rd_vld_b_d[r] = run_d && lane_vld_b[r];
            if (rd_vld_a_d[r]) rd_addr_a_d[r*AW +: AW] = lane_addr_a[r];
            if (rd_vld_b_d[r]) rd_addr_b_d[r*AW +: AW] = lane_addr_b[r];
        end

        // Diagonal d sees its first operands one cycle after lane d issues (read latency).
        pe_en_d = '0;
        for (int d = 0; d < ND; d++) begin
            pe_en_d[d] = run_d && (c_d >= CW'(d + 1)) && (c_d <= CW'(d) + CW'(k_d));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_q         <= '0;
            k_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pe_clr_q    <= 1'b0;
            c_wr_en_q   <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            rd_vld_a_q  <= '0;
            rd_vld_b_q  <= '0;
            pe_en_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            c_q         <= c_d;
            k_q         <= k_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pe_clr_q    <= pe_clr_d;
            c_wr_en_q   <= c_wr_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            rd_vld_a_q  <= rd_vld_a_d;
            rd_vld_b_q  <= rd_vld_b_d;
            pe_en_q     <= pe_en_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pe_clr    = pe_clr_q;
    assign c_wr_en   = c_wr_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign rd_vld_a  = rd_vld_a_q;
    assign rd_vld_b  = rd_vld_b_q;
    assign pe_en     = pe_en_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl against a cycle-indexed job model.
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int KW = 7;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            err;
        logic [N*AW-1:0] aa;
        logic [N-1:0]    va;
        logic [N*AW-1:0] ab;
        logic [N-1:0]    vb;
        logic [2*N-2:0]  pe;
        logic            clr;
        logic            wr;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst_n, start, abort;
    logic [KW-1:0]   k_len;
    logic [AW-1:0]   base_a, base_b;
    logic            busy, done, err, pe_clr, c_wr_en;
    logic [N*AW-1:0] rd_addr_a, rd_addr_b;
    logic [N-1:0]    rd_vld_a, rd_vld_b;
    logic [2*N-2:0]  pe_en;
    obs_t            got;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(N), .AW(AW), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .k_len     (k_len),
        .base_a    (base_a),
        .base_b    (base_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr_a (rd_addr_a),
        .rd_vld_a  (rd_vld_a),
        .rd_addr_b (rd_addr_b),
        .rd_vld_b  (rd_vld_b),
        .pe_en     (pe_en),
        .pe_clr    (pe_clr),
        .c_wr_en   (c_wr_en)
    );

    assign got = {busy, done, err, rd_addr_a, rd_vld_a, rd_addr_b, rd_vld_b, pe_en, pe_clr, c_wr_en};

    // Expected outputs t cycles after the edge that accepted a job.
    function automatic obs_t model(int t, int k, int ba, int bb);
        obs_t e = '0;
        int   c;
        if (t == 0) begin
            e.busy = 1'b1;
            e.clr  = 1'b1;
        end else if (t >= 1 && t <= k + 2*N - 1) begin
            e.busy = 1'b1;
            c = t - 1;
            for (int r = 0; r < N; r++) begin
                if (c >= r && c <= r + k - 1) begin
                    e.va[r] = 1'b1;
                    e.vb[r] = 1'b1;
                    e.aa[r*AW +: AW] = AW'((ba + r*k + (c - r)) % (1 << AW));
                    e.ab[r*AW +: AW] = AW'((bb + r*k + (c - r)) % (1 << AW));
                end
            end
            for (int d = 0; d <= 2*N - 2; d++) e.pe[d] = (c >= d + 1) && (c <= d + k);
        end else if (t == k + 2*N) begin
            e.busy = 1'b1;
            e.wr   = 1'b1;
        end else if (t == k + 2*N + 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    // Launches one job from a negedge and compares every cycle. kill_t >= 0 injects
    // abort (or reset) at that cycle; chain returns in the done cycle for back-to-back use.
    task automatic do_job(input string name, input int k, input int ba, input int bb,
                          input int mid_start_t, input int kill_t, input bit kill_rst, input bit chain);
        obs_t exp;
        int   last_t;
        start  = 1'b1;
        k_len  = KW'(k);
        base_a = AW'(ba);
        base_b = AW'(bb);
        @(negedge clk);
        start = 1'b0;
        if (kill_t >= 0)  last_t = kill_rst ? kill_t + 1 : kill_t + 4;
        else if (chain)   last_t = k + 2*N + 1;
        else              last_t = k + 2*N + 2;
        for (int t = 0; t <= last_t; t++) begin
            exp = (kill_t >= 0 && t > kill_t) ? obs_t'('0) : model(t, k, ba, bb);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
            end
            start = 1'b0;
            abort = 1'b0;
            rst_n = 1'b1;
            if (t == mid_start_t) begin
                start  = 1'b1;
                k_len  = KW'($urandom_range(1, 30));
                base_a = AW'($urandom);
                base_b = AW'($urandom);
            end
            if (t == kill_t) begin
                if (kill_rst) rst_n = 1'b0;
                else          abort = 1'b1;
            end
            if (t != last_t || !(chain || (kill_t >= 0 && kill_rst))) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; k_len = 7'd5; base_a = '0; base_b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_values got=%h expected=0", got);
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%h expected=0", got);
        end
    endtask

    task automatic test_basic();
        do_job("basic_k4", 4, 0, 64, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_k1();
        do_job("k1", 1, int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_k();
        obs_t exp;
        start = 1'b1; k_len = '0; base_a = AW'($urandom); base_b = AW'($urandom);
        @(negedge clk);
        start = 1'b0;
        exp = '0;
        exp.err = 1'b1;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL zero_k_err got=%h expected=%h", got, exp);
        end
        @(negedge clk);
        n_checks++;
        if (got !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL zero_k_after got=%h expected=0", got);
        end
    endtask

    task automatic test_back_to_back();
        do_job("ignore_mid_start", 5, 10, 20, 6, -1, 1'b0, 1'b1);
        do_job("chained_job", 3, 40, 90, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        do_job("abort_c3", 6, 5, 50, -1, 4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        do_job("reset_c6", 6, 8, 30, -1, 7, 1'b1, 1'b0);
        do_job("after_reset", 4, 12, 70, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        do_job("wrap_k8", 8, 100, int'($urandom_range(0, 127)), -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int k, ba, bb;
        for (int i = 0; i < 8; i++) begin
            k  = int'($urandom_range(1, 24));
            ba = int'($urandom_range(0, 128 - N*k));
            bb = int'($urandom_range(0, 128 - N*k));
            do_job("random", k, ba, bb, -1, -1, 1'b0, ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_k1();
        test_zero_k();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
